// File: rtl/phase_couple_driver.sv
// phase_couple_driver: theta-phase-locked coupling drive for one cortical column.
// Tracks the zero crossings of a reference theta oscillator to alternate between
// ENCODE and RETRIEVE. In each sample it forms the phase error of the L2/3 and L6
// oscillators against theta. It scales that error by a coupling gain and drives
// the two layers with opposite signs.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clk_en                sample strobe; all state advances only when high
//   enable                coupling enable (low forces IDLE)
//   theta_x/y             reference theta oscillator state (signed WIDTH)
//   l23_x/y, l6_x/y       column oscillator states (signed WIDTH)
//   phase_couple_l23/l6   registered coupling drives (signed WIDTH)
//   mode                  0 IDLE, 1 ACQUIRE, 2 ENCODE, 3 RETRIEVE
//   locked                high in ENCODE or RETRIEVE
//   theta_period          samples in the last full theta cycle
//
// Optional feature: define PHASE_COUPLE_RAMP_EN to ramp the gain from 0 to
// K_COUPLE over 2^RAMP_SHIFT samples after every ENCODE/RETRIEVE entry.
module phase_couple_driver #(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 14,
    parameter int K_COUPLE   = 1638,
    parameter int MIN_HALF   = 40,
    parameter int MAX_HALF   = 1000,
    parameter int RAMP_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] theta_x,
    input  logic signed [WIDTH-1:0] theta_y,
    input  logic signed [WIDTH-1:0] l23_x,
    input  logic signed [WIDTH-1:0] l23_y,
    input  logic signed [WIDTH-1:0] l6_x,
    input  logic signed [WIDTH-1:0] l6_y,
    output logic signed [WIDTH-1:0] phase_couple_l23,
    output logic signed [WIDTH-1:0] phase_couple_l6,
    output logic [1:0]              mode,
    output logic                    locked,
    output logic [15:0]             theta_period
);
    localparam int unsigned PROD_W = 2 * WIDTH + 1;     // cross-product difference, no overflow
    localparam int unsigned ERR_W  = PROD_W - FRAC;
    localparam int unsigned GAIN_W = WIDTH + 1;
    localparam int unsigned DRV_W  = ERR_W + GAIN_W;
    localparam int unsigned CNT_W  = 16;
    localparam logic signed [DRV_W-1:0] DRV_MAX = DRV_W'((2 ** (WIDTH - 1)) - 1);

    if (MIN_HALF >= MAX_HALF || RAMP_SHIFT < 0 || RAMP_SHIFT > 8) begin : g_bad_params
        $error("phase_couple_driver: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACQUIRE  = 2'd1,
        ENCODE   = 2'd2,
        RETRIEVE = 2'd3
    } state_t;

    state_t                   state, state_next, st1_state;
    logic                     prev_neg, neg_now, rise, fall;
    logic                     long_enough, timeout, accept, load_period;
    logic [CNT_W-1:0]         half_cnt, last_half, half_len;
    logic [CNT_W:0]           period_sum;
    logic signed [ERR_W-1:0]  err_l23_c, err_l6_c, err1_l23, err1_l6;
    logic signed [GAIN_W-1:0] gain_c, gain1;
    logic signed [WIDTH-1:0]  drv_l23_c, drv_l6_c;

    // Scale an error by the gain, drop FRAC bits (floor) and clamp symmetrically.
    function automatic logic signed [WIDTH-1:0] scale_clamp(
        input logic signed [GAIN_W-1:0] g,
        input logic signed [ERR_W-1:0]  e
    );
        logic signed [DRV_W-1:0] p;
        p = (DRV_W'(g) * DRV_W'(e)) >>> FRAC;
        if (p > DRV_MAX) begin
            p = DRV_MAX;
        end else if (p < -DRV_MAX) begin
            p = -DRV_MAX;
        end
        return WIDTH'(p);
    endfunction

    // Crossing detection against the sign seen at the previous sample.
    assign neg_now     = theta_y[WIDTH-1];
    assign rise        = prev_neg & ~neg_now;
    assign fall        = ~prev_neg & neg_now;
    assign long_enough = (half_cnt >= CNT_W'(MIN_HALF));
    assign timeout     = (half_cnt == CNT_W'(MAX_HALF));
    // The crossing sample itself belongs to the half that it closes.
    assign half_len    = half_cnt + CNT_W'(1);
    assign period_sum  = (CNT_W + 1)'(last_half) + (CNT_W + 1)'(half_len);

    // Next-state logic; enable has priority over crossings.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        load_period = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = ACQUIRE;
                ACQUIRE: begin
                    if (rise && long_enough) begin
                        state_next = ENCODE;
                        accept     = 1'b1;
                    end
                end
                ENCODE: begin
                    if (timeout) begin
                        state_next = ACQUIRE;
                    end else if (fall && long_enough) begin
                        state_next = RETRIEVE;
                        accept     = 1'b1;
                    end
                end
                RETRIEVE: begin
                    if (timeout) begin
                        state_next = ACQUIRE;
                    end else if (rise && long_enough) begin
                        state_next  = ENCODE;
                        accept      = 1'b1;
                        load_period = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, sign history, half-period counter and period measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            locked       <= 1'b0;
            prev_neg     <= 1'b0;
            half_cnt     <= '0;
            last_half    <= '0;
            theta_period <= '0;
        end else if (clk_en) begin
            state    <= state_next;
            locked   <= (state_next == ENCODE) || (state_next == RETRIEVE);
            prev_neg <= neg_now;
            if (!enable || state == IDLE || accept) begin
                half_cnt <= '0;
            end else if (half_cnt != CNT_W'(MAX_HALF)) begin
                half_cnt <= half_cnt + CNT_W'(1);
            end
            if (accept) begin
                last_half <= half_len;
            end
            if (load_period) begin
                theta_period <= period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];
            end
        end
    end

    assign mode = state;

`ifdef PHASE_COUPLE_RAMP_EN
    localparam int unsigned RAMP_W = RAMP_SHIFT + 1;
    localparam logic [RAMP_W-1:0] RAMP_TOP = RAMP_W'(2 ** RAMP_SHIFT);
    logic [RAMP_W-1:0] ramp;

    assign gain_c = GAIN_W'((K_COUPLE * int'(ramp)) >>> RAMP_SHIFT);

    // Ramp restarts on every ENCODE/RETRIEVE entry and saturates at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp <= '0;
        end else if (clk_en) begin
            if ((state_next == ENCODE || state_next == RETRIEVE) && state_next != state) begin
                ramp <= '0;
            end else if (ramp != RAMP_TOP) begin
                ramp <= ramp + RAMP_W'(1);
            end
        end
    end
`else
    assign gain_c = GAIN_W'(K_COUPLE);
`endif

    // Stage-1 phase errors at full product precision.
    assign err_l23_c = ERR_W'((PROD_W'(theta_y) * PROD_W'(l23_x)
                             - PROD_W'(theta_x) * PROD_W'(l23_y)) >>> FRAC);
    assign err_l6_c  = ERR_W'((PROD_W'(theta_y) * PROD_W'(l6_x)
                             - PROD_W'(theta_x) * PROD_W'(l6_y)) >>> FRAC);

    assign drv_l23_c = scale_clamp(gain1, err1_l23);
    assign drv_l6_c  = scale_clamp(gain1, err1_l6);

    // Two-stage pipeline; stage 2 uses the state and gain captured with stage 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err1_l23         <= '0;
            err1_l6          <= '0;
            gain1            <= '0;
            st1_state        <= IDLE;
            phase_couple_l23 <= '0;
            phase_couple_l6  <= '0;
        end else if (clk_en) begin
            err1_l23  <= err_l23_c;
            err1_l6   <= err_l6_c;
            gain1     <= gain_c;
            st1_state <= state;
            case (st1_state)
                ENCODE: begin
                    phase_couple_l23 <= drv_l23_c;
                    phase_couple_l6  <= -drv_l6_c;
                end
                RETRIEVE: begin
                    phase_couple_l23 <= -drv_l23_c;
                    phase_couple_l6  <= drv_l6_c;
                end
                default: begin
                    phase_couple_l23 <= '0;
                    phase_couple_l6  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_couple_driver.sv
// Scoreboard bench for phase_couple_driver (default build, constant gain).
// A sample-level reference model predicts mode, lock, period and both drives;
// predictions are queued by the driver and consumed by an independent monitor.
module tb_phase_couple_driver;
    localparam int     W    = 18;
    localparam int     FRAC = 14;
    localparam int     K    = 1638;
    localparam int     MINH = 40;
    localparam int     MAXH = 1000;
    localparam longint DMAX = (longint'(1) <<< (W - 1)) - 1;

    logic clk = 1'b0;
    logic rst, clk_en, enable;
    logic signed [W-1:0] theta_x, theta_y, l23_x, l23_y, l6_x, l6_y;
    logic signed [W-1:0] pc_l23, pc_l6;
    logic [1:0]  mode;
    logic        locked;
    logic [15:0] theta_period;

    always #5 clk = ~clk;

    phase_couple_driver dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .enable(enable),
        .theta_x(theta_x), .theta_y(theta_y),
        .l23_x(l23_x), .l23_y(l23_y), .l6_x(l6_x), .l6_y(l6_y),
        .phase_couple_l23(pc_l23), .phase_couple_l6(pc_l6),
        .mode(mode), .locked(locked), .theta_period(theta_period)
    );

    typedef struct {
        int     mode;
        int     locked;
        int     period;
        longint l23;
        longint l6;
    } exp_t;

    exp_t expq[$];
    exp_t last;
    bit   mon_on = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Staged stimulus, applied by tick() at the falling edge.
    bit          s_en;
    int          s_tx, s_ty, s_ax, s_ay, s_bx, s_by;
    int          maxgap = 0;

    // Reference model state.
    int     m_mode, m_cnt, m_period;
    bit     m_prev_neg;
    int     m_halves[$];
    longint p_e23, p_e6, o23, o6;
    int     p_mode;

    task automatic cmp(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint clampv(input longint v);
        if (v > DMAX) return DMAX;
        if (v < -DMAX) return -DMAX;
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_period = 0; m_prev_neg = 1'b0;
        m_halves.delete();
        p_e23 = 0; p_e6 = 0; p_mode = 0; o23 = 0; o6 = 0;
    endtask

    // One accepted sample: drives come from the sample before, then the state rules apply.
    task automatic model_step();
        longint d23, d6;
        bit neg, rise, fall, take;
        d23 = clampv((K * p_e23) >>> FRAC);
        d6  = clampv((K * p_e6) >>> FRAC);
        if (p_mode == 2)      begin o23 = d23;  o6 = -d6; end
        else if (p_mode == 3) begin o23 = -d23; o6 = d6;  end
        else                  begin o23 = 0;    o6 = 0;   end
        p_e23  = (longint'(s_ty) * s_ax - longint'(s_tx) * s_ay) >>> FRAC;
        p_e6   = (longint'(s_ty) * s_bx - longint'(s_tx) * s_by) >>> FRAC;
        p_mode = m_mode;
        neg  = (s_ty < 0);
        rise = m_prev_neg && !neg;
        fall = !m_prev_neg && neg;
        m_prev_neg = neg;
        take = 1'b0;
        if (!s_en) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_cnt = 0;
        end else begin
            if (m_mode != 1 && m_cnt == MAXH) m_mode = 1;
            else if (m_cnt >= MINH && ((m_mode == 2 && fall) || (m_mode != 2 && rise))) take = 1'b1;
            if (take) begin
                m_halves.push_back(m_cnt + 1);
                if (m_halves.size() > 2) void'(m_halves.pop_front());
                if (m_mode == 3 && m_halves.size() == 2)
                    m_period = (m_halves[0] + m_halves[1] > 65535) ? 65535 : m_halves[0] + m_halves[1];
                m_mode = (m_mode == 2) ? 3 : 2;
                m_cnt = 0;
            end else if (m_cnt < MAXH) begin
                m_cnt++;
            end
        end
    endtask

    // Apply staged inputs for one cycle and queue the predicted response.
    task automatic tick(input bit strobe, input bit do_rst);
        exp_t e;
        @(negedge clk);
        rst = do_rst; clk_en = strobe; enable = s_en;
        theta_x = W'(s_tx); theta_y = W'(s_ty);
        l23_x = W'(s_ax); l23_y = W'(s_ay); l6_x = W'(s_bx); l6_y = W'(s_by);
        if (do_rst) begin
            model_reset();
            mon_on = 1'b1;
        end else if (strobe) begin
            model_step();
        end
        if (do_rst || strobe) begin
            e.mode = m_mode; e.locked = (m_mode >= 2) ? 1 : 0; e.period = m_period;
            e.l23 = o23; e.l6 = o6;
            expq.push_back(e);
        end
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_osc();
        s_ax = int'(W'($urandom)); s_ay = int'(W'($urandom));
        s_bx = int'(W'($urandom)); s_by = int'(W'($urandom));
        if (s_ax >= 131072) s_ax -= 262144;
        if (s_ay >= 131072) s_ay -= 262144;
        if (s_bx >= 131072) s_bx -= 262144;
        if (s_by >= 131072) s_by -= 262144;
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Monitor: compare after every edge; between strobes outputs must hold.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (expq.size() > 0) last = expq.pop_front();
                cmp("mode", longint'(mode), longint'(last.mode));
                cmp("locked", longint'(locked), longint'(last.locked));
                cmp("theta_period", longint'(theta_period), longint'(last.period));
                cmp("pc_l23", longint'(pc_l23), last.l23);
                cmp("pc_l6", longint'(pc_l6), last.l6);
            end
        end
    end

    initial begin
        real ph;
        int  remain, en_off;
        bit  cur_neg;
        rst = 1'b1; clk_en = 1'b0; enable = 1'b0;
        theta_x = '0; theta_y = '0; l23_x = '0; l23_y = '0; l6_x = '0; l6_y = '0;
        s_en = 1'b0; s_tx = 0; s_ty = 0; s_ax = 0; s_ay = 0; s_bx = 0; s_by = 0;
        model_reset();

        // Reset, including one with the strobe high.
        tick(1'b0, 1'b1);
        s_en = 1'b1;
        tick(1'b1, 1'b1);
        settle();
        cmp("reset_mode", longint'(mode), 0);
        cmp("reset_pc_l23", longint'(pc_l23), 0);
        cmp("reset_period", longint'(theta_period), 0);

        // 420-sample theta sine: lock on the first rising crossing, 210-sample halves.
        maxgap = 1;
        for (int n = 0; n < 1265; n++) begin
            ph = 2.0 * 3.14159265358979 * (real'(n) + 0.5) / 420.0;
            s_tx = rnd(16000.0 * $cos(ph));
            s_ty = rnd(16000.0 * $sin(ph));
            rand_osc();
            strobe(1);
        end
        settle();
        cmp("sine_mode", longint'(mode), 2);
        cmp("sine_period", longint'(theta_period), 420);

        // Known-value drive in ENCODE, then in RETRIEVE.
        maxgap = 0;
        s_tx = 8192; s_ty = 0; s_ax = 0; s_ay = 8192; s_bx = 0; s_by = 8192;
        strobe(50);
        settle();
        cmp("enc_pc_l23", longint'(pc_l23), -410);
        cmp("enc_pc_l6", longint'(pc_l6), 410);
        s_ty = -1;
        strobe(3);
        settle();
        cmp("ret_mode", longint'(mode), 3);
        cmp("ret_pc_l23", longint'(pc_l23), 410);
        cmp("ret_pc_l6", longint'(pc_l6), -410);

        // Sign toggle 10 samples after the crossing is ignored; frozen theta times out.
        strobe(7);
        s_ty = 1;
        strobe(21);
        settle();
        cmp("glitch_mode", longint'(mode), 3);
        strobe(1000);
        settle();
        cmp("timeout_mode", longint'(mode), 1);
        cmp("timeout_pc_l23", longint'(pc_l23), 0);
        cmp("timeout_pc_l6", longint'(pc_l6), 0);

        // Re-lock, then drop enable on the same sample as a valid falling crossing.
        s_ty = -1; strobe(50);
        s_ty = 1;  strobe(61);
        settle();
        cmp("relock_pc_l23", longint'(pc_l23), -410);
        s_ty = -1; s_en = 1'b0;
        strobe(1);
        settle();
        cmp("disable_mode", longint'(mode), 0);
        cmp("disable_locked", longint'(locked), 0);
        strobe(2);
        settle();
        cmp("disable_pc_l23", longint'(pc_l23), 0);
        cmp("disable_pc_l6", longint'(pc_l6), 0);

        // Reset in the middle of ENCODE with nonzero drive and clk_en low.
        s_en = 1'b1;
        strobe(50);
        s_ty = 1; strobe(6);
        settle();
        cmp("pre_rst_pc_l23", longint'(pc_l23), -410);
        tick(1'b0, 1'b1);
        settle();
        cmp("mid_rst_mode", longint'(mode), 0);
        cmp("mid_rst_locked", longint'(locked), 0);
        cmp("mid_rst_pc_l23", longint'(pc_l23), 0);
        cmp("mid_rst_pc_l6", longint'(pc_l6), 0);
        cmp("mid_rst_period", longint'(theta_period), 0);

        // Randomized theta half-periods (glitches, nominal, timeouts), enable drops, resets.
        maxgap = 2; remain = 0; en_off = 0; cur_neg = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (remain == 0) begin
                int r;
                cur_neg = !cur_neg;
                r = $urandom_range(0, 9);
                remain = (r < 2) ? $urandom_range(3, 39) :
                         (r < 9) ? $urandom_range(40, 300) : $urandom_range(990, 1010);
            end
            remain--;
            if (en_off == 0 && $urandom_range(0, 199) == 0) en_off = $urandom_range(1, 20);
            s_en = (en_off == 0);
            if (en_off > 0) en_off--;
            s_ty = cur_neg ? -int'($urandom_range(1, 131072)) : int'($urandom_range(0, 131071));
            s_tx = int'($urandom_range(0, 262142)) - 131071;
            rand_osc();
            if ($urandom_range(0, 999) == 0) tick(1'($urandom_range(0, 1)), 1'b1);
            else strobe(1);
        end

        repeat (3) tick(1'b0, 1'b0);
        settle();
        cmp("queue_drained", longint'(expq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
